// File: rtl/store_rmw_ctrl.sv
// Store sequencer for a word-wide data RAM with a registered read port.
// SB/SH become read-modify-write; aligned SW is a single write; misaligned stores are rejected.
module store_rmw_ctrl #(
    parameter int ADDR_W     = 10,
    parameter int MEM_RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [31:0]       req_addr_i,
    input  logic [31:0]       req_wdata_i,
    input  logic [1:0]        req_size_i,
    output logic              done_o,
    output logic              misalign_err_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_rd_en_o,
    input  logic [31:0]       mem_rdata_i,
    output logic              mem_wr_en_o,
    output logic [31:0]       mem_wdata_o
);

    localparam int               CNT_W    = (MEM_RD_LAT > 1) ? $clog2(MEM_RD_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_RD_LAT - 1);

    typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, ERR} state_e;

    state_e             state_q;
    logic [1:0]         offset_q;
    logic               byte_q;
    logic [15:0]        wdata_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               ready_q;
    logic               done_q;
    logic               misalign_q;
    logic               rd_en_q;
    logic               wr_en_q;
    logic [ADDR_W-1:0]  maddr_q;
    logic [31:0]        mwdata_q;

    logic               misalign_d;
    logic [31:0]        merged_d;
    logic               unused_addr_hi;

    // Byte address bits above the RAM's reach are deliberately ignored.
    assign unused_addr_hi = ^req_addr_i[31:ADDR_W+2];

    always_comb begin
        misalign_d = 1'b0;
        case (req_size_i)
            2'b00:   misalign_d = 1'b0;
            2'b01:   misalign_d = req_addr_i[0];
            2'b10:   misalign_d = (req_addr_i[1:0] != 2'b00);
            default: misalign_d = 1'b1;
        endcase
    end

    // Little-endian lane insert of the latched store data into the word just read.
    always_comb begin
        merged_d = mem_rdata_i;
        if (byte_q) begin
            merged_d[{offset_q, 3'b000} +: 8] = wdata_q[7:0];
        end else if (offset_q[1]) begin
            merged_d[31:16] = wdata_q;
        end else begin
            merged_d[15:0] = wdata_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            offset_q   <= 2'b00;
            byte_q     <= 1'b0;
            wdata_q    <= 16'h0000;
            cnt_q      <= '0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            misalign_q <= 1'b0;
            rd_en_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            maddr_q    <= '0;
            mwdata_q   <= 32'h0000_0000;
        end else begin
            done_q     <= 1'b0;
            misalign_q <= 1'b0;
            rd_en_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid_i && ready_q) begin
                        offset_q <= req_addr_i[1:0];
                        byte_q   <= (req_size_i == 2'b00);
                        wdata_q  <= req_wdata_i[15:0];
                        ready_q  <= 1'b0;
                        if (misalign_d) begin
                            state_q    <= ERR;
                            done_q     <= 1'b1;
                            misalign_q <= 1'b1;
                        end else begin
                            maddr_q <= req_addr_i[ADDR_W+1:2];
                            if (req_size_i == 2'b10) begin
                                state_q  <= WRITE;
                                wr_en_q  <= 1'b1;
                                done_q   <= 1'b1;
                                mwdata_q <= req_wdata_i;
                            end else begin
                                state_q <= READ;
                                rd_en_q <= 1'b1;
                            end
                        end
                    end
                end
                READ: begin
                    state_q <= WAIT;
                    cnt_q   <= CNT_LOAD;
                end
                // Read data is valid in the cycle the counter reaches zero.
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_q  <= WRITE;
                        mwdata_q <= merged_d;
                        wr_en_q  <= 1'b1;
                        done_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                WRITE, ERR: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready_o    = ready_q;
    assign done_o         = done_q;
    assign misalign_err_o = misalign_q;
    assign mem_addr_o     = maddr_q;
    assign mem_rd_en_o    = rd_en_q;
    assign mem_wr_en_o    = wr_en_q;
    assign mem_wdata_o    = mwdata_q;

endmodule

// File: tb/tb_store_rmw_ctrl.sv
// Self-checking bench for store_rmw_ctrl: directed vector table, reset/latency sequences,
// and random stores scored against a word-memory model built from the lane-merge rules.
module tb_store_rmw_ctrl;

    localparam int LAT1 = 1;
    localparam int LAT3 = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        reqValid, reqValid3;
    logic [31:0] reqAddr, reqWdata;
    logic [1:0]  reqSize;

    logic        reqReady, done, misErr, memRdEn, memWrEn;
    logic [9:0]  memAddr;
    logic [31:0] memRdata, memWdata;

    logic        reqReady3, done3, misErr3, memRdEn3, memWrEn3;
    logic [9:0]  memAddr3;
    logic [31:0] memRdata3, memWdata3, pipe1, pipe2;

    logic [31:0] ram1 [0:1023];
    logic [31:0] ram3 [0:1023];
    logic [31:0] refMem [0:1023];

    logic        preEn;
    logic [9:0]  preAddr;
    logic [31:0] preData;

    int checks = 0;
    int errors = 0;
    int overlapErr = 0;

    always #5 clk = ~clk;

    store_rmw_ctrl #(.ADDR_W(10), .MEM_RD_LAT(LAT1)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(reqValid), .req_ready_o(reqReady),
        .req_addr_i(reqAddr), .req_wdata_i(reqWdata), .req_size_i(reqSize),
        .done_o(done), .misalign_err_o(misErr),
        .mem_addr_o(memAddr), .mem_rd_en_o(memRdEn), .mem_rdata_i(memRdata),
        .mem_wr_en_o(memWrEn), .mem_wdata_o(memWdata)
    );

    store_rmw_ctrl #(.ADDR_W(10), .MEM_RD_LAT(LAT3)) dut3 (
        .clk(clk), .rst(rst),
        .req_valid_i(reqValid3), .req_ready_o(reqReady3),
        .req_addr_i(reqAddr), .req_wdata_i(reqWdata), .req_size_i(reqSize),
        .done_o(done3), .misalign_err_o(misErr3),
        .mem_addr_o(memAddr3), .mem_rd_en_o(memRdEn3), .mem_rdata_i(memRdata3),
        .mem_wr_en_o(memWrEn3), .mem_wdata_o(memWdata3)
    );

    // RAM models: one-cycle read for dut, three-stage read pipe for dut3.
    always @(posedge clk) begin
        if (memWrEn) ram1[memAddr] <= memWdata;
        else if (preEn) ram1[preAddr] <= preData;
        if (memRdEn) memRdata <= ram1[memAddr];
        if (memWrEn3) ram3[memAddr3] <= memWdata3;
        else if (preEn) ram3[preAddr] <= preData;
        pipe1     <= memRdEn3 ? ram3[memAddr3] : 32'h0;
        pipe2     <= pipe1;
        memRdata3 <= pipe2;
    end

    always @(negedge clk) begin
        if ((memRdEn && memWrEn) || (memRdEn3 && memWrEn3)) overlapErr <= overlapErr + 1;
    end

    typedef struct {
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] data;
        logic        doPre;
        logic [31:0] preVal;
        logic        expMis;
        int          expLat;
        logic [31:0] expWdata;
    } vec_t;

    vec_t vecs [14];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [1:0] size,
                                 input logic [31:0] addr, input logic [31:0] data);
        reqValid = valid;
        reqSize  = size;
        reqAddr  = addr;
        reqWdata = data;
    endtask

    task automatic preloadWord(input logic [9:0] idx, input logic [31:0] val);
        @(negedge clk);
        preEn   = 1'b1;
        preAddr = idx;
        preData = val;
        @(negedge clk);
        preEn   = 1'b0;
        refMem[idx] = val;
    endtask

    function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] off);
        return (size == 2'd3) || (size == 2'd2 && off != 2'd0) || (size == 2'd1 && off[0]);
    endfunction

    function automatic logic [31:0] modelMerge(input logic [1:0] size, input logic [1:0] off,
                                               input logic [31:0] oldW, input logic [31:0] d);
        int          sh;
        logic [31:0] mask;
        if (size == 2'd2) return d;
        if (size == 2'd0) begin
            sh   = 8 * int'(off);
            mask = 32'hFF << sh;
            return (oldW & ~mask) | ((d & 32'hFF) << sh);
        end
        sh   = off[1] ? 16 : 0;
        mask = 32'hFFFF << sh;
        return (oldW & ~mask) | ((d & 32'hFFFF) << sh);
    endfunction

    task automatic runStore(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] data,
                            input logic expMis, input int expLat, input logic [31:0] expWdata,
                            input string tag);
        int          waitCyc, doneCyc, rdCyc, wrCount;
        logic [31:0] wrData;
        logic [9:0]  wrAddr;
        logic        misAtDone;
        waitCyc = 0;
        @(negedge clk);
        while (!reqReady && waitCyc < 20) begin
            @(negedge clk);
            waitCyc++;
        end
        checkOutput({tag, ":readyBeforeAccept"}, 32'(reqReady), 32'd1);
        if (!reqReady) return;
        applyStimulus(1'b1, size, addr, data);
        @(posedge clk);
        doneCyc = 0; rdCyc = 0; wrCount = 0; wrData = 0; wrAddr = 0; misAtDone = 0;
        for (int c = 1; c <= 20 && doneCyc == 0; c++) begin
            @(negedge clk);
            if (c == 1) reqValid = 1'b0;
            if (memRdEn && rdCyc == 0) rdCyc = c;
            if (memWrEn) begin
                wrCount++;
                wrData = memWdata;
                wrAddr = memAddr;
            end
            if (done) begin
                doneCyc   = c;
                misAtDone = misErr;
            end
        end
        checkOutput({tag, ":doneCycle"}, 32'(doneCyc), 32'(expLat));
        checkOutput({tag, ":misalignErr"}, 32'(misAtDone), 32'(expMis));
        checkOutput({tag, ":writeCount"}, 32'(wrCount), expMis ? 32'd0 : 32'd1);
        checkOutput({tag, ":readCycle"}, 32'(rdCyc), (!expMis && size != 2'd2) ? 32'd1 : 32'd0);
        if (!expMis) begin
            checkOutput({tag, ":memWdata"}, wrData, expWdata);
            checkOutput({tag, ":memAddr"}, 32'(wrAddr), 32'(addr[11:2]));
            refMem[addr[11:2]] = expWdata;
        end
        @(negedge clk);
        checkOutput({tag, ":readyAfterDone"}, 32'(reqReady), 32'd1);
    endtask

    initial begin
        int          wrCnt;
        int          rdQ[$];
        int          wrQ[$];
        logic [31:0] wdQ[$];
        logic        ready5, ready6;
        logic [1:0]  rSize, rOff;
        logic [9:0]  rIdx;
        logic [31:0] rHi, rAddr, rData, rExp;
        logic        rMis;
        int          rLat;

        rst = 1'b1; reqValid = 1'b0; reqValid3 = 1'b0; preEn = 1'b0;
        preAddr = '0; preData = '0;
        applyStimulus(1'b0, 2'b00, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        checkOutput("reset:reqReady", 32'(reqReady), 32'd1);
        checkOutput("reset:done", 32'(done), 32'd0);
        checkOutput("reset:misalignErr", 32'(misErr), 32'd0);
        checkOutput("reset:memRdEn", 32'(memRdEn), 32'd0);
        checkOutput("reset:memWrEn", 32'(memWrEn), 32'd0);
        checkOutput("reset:memAddr", 32'(memAddr), 32'd0);
        checkOutput("reset:memWdata", memWdata, 32'd0);
        checkOutput("reset:reqReady3", 32'(reqReady3), 32'd1);
        rst = 1'b0;

        vecs[0]  = '{2'd2, 32'h0000_0010, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 1, 32'hDEADBEEF};
        vecs[1]  = '{2'd0, 32'h0000_0022, 32'h0000_00AB, 1'b1, 32'h11223344, 1'b0, 3, 32'h11AB3344};
        vecs[2]  = '{2'd1, 32'h0000_0006, 32'h0000_CAFE, 1'b1, 32'h11223344, 1'b0, 3, 32'hCAFE3344};
        vecs[3]  = '{2'd1, 32'h0000_0004, 32'h0000_CAFE, 1'b1, 32'h11223344, 1'b0, 3, 32'h1122CAFE};
        vecs[4]  = '{2'd0, 32'h0000_0020, 32'hFFFF_FF01, 1'b1, 32'h11223344, 1'b0, 3, 32'h11223301};
        vecs[5]  = '{2'd0, 32'h0000_0021, 32'h0000_005A, 1'b1, 32'h11223344, 1'b0, 3, 32'h11225A44};
        vecs[6]  = '{2'd0, 32'h0000_0023, 32'h0000_0077, 1'b1, 32'h11223344, 1'b0, 3, 32'h77223344};
        vecs[7]  = '{2'd2, 32'h8000_0FFC, 32'h0BAD_F00D, 1'b0, 32'h0,        1'b0, 1, 32'h0BADF00D};
        vecs[8]  = '{2'd1, 32'h0000_0003, 32'h0000_1234, 1'b0, 32'h0,        1'b1, 1, 32'h0};
        vecs[9]  = '{2'd2, 32'h0000_0002, 32'h1234_5678, 1'b0, 32'h0,        1'b1, 1, 32'h0};
        vecs[10] = '{2'd3, 32'h0000_0000, 32'h1234_5678, 1'b0, 32'h0,        1'b1, 1, 32'h0};
        vecs[11] = '{2'd1, 32'h0000_0001, 32'h0000_BEEF, 1'b0, 32'h0,        1'b1, 1, 32'h0};
        vecs[12] = '{2'd2, 32'h0000_0001, 32'h1111_2222, 1'b0, 32'h0,        1'b1, 1, 32'h0};
        vecs[13] = '{2'd1, 32'h0000_0042, 32'hBEEF_1234, 1'b1, 32'hA5A5A5A5, 1'b0, 3, 32'h1234A5A5};

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].doPre) preloadWord(vecs[i].addr[11:2], vecs[i].preVal);
            runStore(vecs[i].size, vecs[i].addr, vecs[i].data, vecs[i].expMis,
                     vecs[i].expLat, vecs[i].expWdata, $sformatf("vec%0d", i));
        end

        // Reset in the middle of a sub-word store must drop it without writing.
        preloadWord(10'd8, 32'h11223344);
        @(negedge clk);
        applyStimulus(1'b1, 2'd0, 32'h0000_0022, 32'h0000_00AB);
        @(posedge clk);
        @(negedge clk);
        reqValid = 1'b0;
        checkOutput("rstWait:readCycle1", 32'(memRdEn), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("rstWait:reqReady", 32'(reqReady), 32'd1);
        checkOutput("rstWait:memWrEn", 32'(memWrEn), 32'd0);
        checkOutput("rstWait:done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wrCnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (memWrEn) wrCnt++;
        end
        checkOutput("rstWait:noWrite", 32'(wrCnt), 32'd0);
        runStore(2'd2, 32'h0000_0040, 32'h1234_5678, 1'b0, 1, 32'h12345678, "rstWait:nextSW");

        // Three-cycle RAM, byte store held valid across two back-to-back requests.
        preloadWord(10'd0, 32'h11223344);
        @(negedge clk);
        checkOutput("lat3:readyIdle", 32'(reqReady3), 32'd1);
        reqValid3 = 1'b1; reqSize = 2'd0; reqAddr = 32'h0000_0001; reqWdata = 32'h0000_00AB;
        @(posedge clk);
        ready5 = 1'b1; ready6 = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 7) reqValid3 = 1'b0;
            if (c == 5) ready5 = reqReady3;
            if (c == 6) ready6 = reqReady3;
            if (memRdEn3) rdQ.push_back(c);
            if (memWrEn3) begin
                wrQ.push_back(c);
                wdQ.push_back(memWdata3);
            end
        end
        checkOutput("lat3:readCount", 32'(rdQ.size()), 32'd2);
        checkOutput("lat3:writeCount", 32'(wrQ.size()), 32'd2);
        checkOutput("lat3:read1Cycle", (rdQ.size() > 0) ? 32'(rdQ[0]) : 32'd0, 32'd1);
        checkOutput("lat3:write1Cycle", (wrQ.size() > 0) ? 32'(wrQ[0]) : 32'd0, 32'd5);
        checkOutput("lat3:write1Data", (wdQ.size() > 0) ? wdQ[0] : 32'd0, 32'h1122AB44);
        checkOutput("lat3:readyDuringWrite", 32'(ready5), 32'd0);
        checkOutput("lat3:readyAfterDone", 32'(ready6), 32'd1);
        checkOutput("lat3:read2Cycle", (rdQ.size() > 1) ? 32'(rdQ[1]) : 32'd0, 32'd7);
        checkOutput("lat3:write2Cycle", (wrQ.size() > 1) ? 32'(wrQ[1]) : 32'd0, 32'd11);
        checkOutput("lat3:write2Data", (wdQ.size() > 1) ? wdQ[1] : 32'd0, 32'h1122AB44);

        // Random stores over a small word window so read-modify-writes collide.
        for (int w = 0; w < 16; w++) preloadWord(10'(w), $urandom);
        for (int i = 0; i < 60; i++) begin
            rSize = 2'($urandom_range(0, 3));
            rIdx  = 10'($urandom_range(0, 15));
            rOff  = 2'($urandom_range(0, 3));
            rHi   = $urandom;
            rAddr = {rHi[19:0], rIdx, rOff};
            rData = $urandom;
            rMis  = isMisaligned(rSize, rOff);
            rExp  = modelMerge(rSize, rOff, refMem[rIdx], rData);
            rLat  = (rMis || rSize == 2'd2) ? 1 : 2 + LAT1;
            runStore(rSize, rAddr, rData, rMis, rLat, rExp, $sformatf("rand%0d", i));
        end

        checkOutput("noRdWrOverlap", 32'(overlapErr), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
